// File: rtl/tournament_bp.sv
`default_nettype none
// ============================================================================
// Module   : tournament_bp
// Brief    : Tournament branch predictor; a choice table arbitrates between a
//            gshare component and a local-history (or bimodal) component.
// Options  : define TOURNAMENT_BP_LOCAL_EN to build the local-history path.
// Revision : 1.0 - initial release
// ============================================================================
module tournament_bp #(
    parameter int CTR_BITS    = 2,
    parameter int BIM_ENTRIES = 1024,
    parameter int GLB_ENTRIES = 1024,
    parameter int CHO_ENTRIES = 1024,
    parameter int LCL_ENTRIES = 1024,
    parameter int LHT_ENTRIES = 1024,
    parameter int RVC         = 1,
    localparam int GHR_BITS   = $clog2(GLB_ENTRIES)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                lookup_valid_i,
    input  logic [63:0]         lookup_pc_i,
    output logic                pred_valid_o,
    output logic                pred_taken_o,
    output logic [GHR_BITS-1:0] pred_ghr_o,
    input  logic                upd_valid_i,
    input  logic [63:0]         upd_pc_i,
    input  logic                upd_taken_i,
    input  logic [GHR_BITS-1:0] upd_ghr_i,
    output logic                ready_o
);

    localparam int c_OFS      = (RVC == 1) ? 1 : 2;
    localparam int c_BIM_BITS = $clog2(BIM_ENTRIES);
    localparam int c_CHO_BITS = $clog2(CHO_ENTRIES);
    localparam int c_MAX_0    = (BIM_ENTRIES > GLB_ENTRIES) ? BIM_ENTRIES : GLB_ENTRIES;
    localparam int c_MAX_1    = (c_MAX_0 > CHO_ENTRIES) ? c_MAX_0 : CHO_ENTRIES;
    localparam int c_MAX_2    = (c_MAX_1 > LCL_ENTRIES) ? c_MAX_1 : LCL_ENTRIES;
    localparam int c_MAX_DEPTH = (c_MAX_2 > LHT_ENTRIES) ? c_MAX_2 : LHT_ENTRIES;
    localparam int c_SW_BITS  = $clog2(c_MAX_DEPTH) + 1;

    localparam logic [c_SW_BITS-1:0] c_SW_LAST = c_SW_BITS'(c_MAX_DEPTH - 1);
    localparam logic [c_SW_BITS-1:0] c_BIM_LIM = c_SW_BITS'(BIM_ENTRIES);
    localparam logic [c_SW_BITS-1:0] c_GLB_LIM = c_SW_BITS'(GLB_ENTRIES);
    localparam logic [c_SW_BITS-1:0] c_CHO_LIM = c_SW_BITS'(CHO_ENTRIES);

    localparam logic [CTR_BITS-1:0] c_CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] c_CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};

    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

`ifdef TOURNAMENT_BP_LOCAL_EN
    localparam int c_LHT_BITS = $clog2(LHT_ENTRIES);
    localparam int c_LH_BITS  = $clog2(LCL_ENTRIES);
    localparam logic [c_SW_BITS-1:0] c_LHT_LIM = c_SW_BITS'(LHT_ENTRIES);
    localparam logic [c_SW_BITS-1:0] c_LCL_LIM = c_SW_BITS'(LCL_ENTRIES);
`endif

    function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] ctr,
                                                     input logic up);
        logic [CTR_BITS-1:0] res;
        res = ctr;
        if (up && (ctr != c_CTR_MAX)) begin
            res = ctr + 1'b1;
        end else if (!up && (ctr != '0)) begin
            res = ctr - 1'b1;
        end
        return res;
    endfunction

    logic [CTR_BITS-1:0] r_bim_q [BIM_ENTRIES];
    logic [CTR_BITS-1:0] r_glb_q [GLB_ENTRIES];
    logic [CTR_BITS-1:0] r_cho_q [CHO_ENTRIES];
`ifdef TOURNAMENT_BP_LOCAL_EN
    logic [c_LH_BITS-1:0] r_lht_q [LHT_ENTRIES];
    logic [CTR_BITS-1:0]  r_lcl_q [LCL_ENTRIES];
`endif

    logic [0:0]           r_state_q, w_state_d;
    logic [c_SW_BITS-1:0] r_sweep_q, w_sweep_d;
    logic [GHR_BITS-1:0]  r_ghr_q, w_ghr_d;
    logic                 r_pred_valid_q, w_pred_valid_d;
    logic                 r_pred_taken_q, w_pred_taken_d;
    logic [GHR_BITS-1:0]  r_pred_ghr_q, w_pred_ghr_d;
    logic                 w_ready;
    logic                 w_lk_fire;
    logic                 w_up_fire;
    logic                 w_unused_pc;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q      <= c_ST_INIT;
            r_sweep_q      <= '0;
            r_ghr_q        <= '0;
            r_pred_valid_q <= 1'b0;
            r_pred_taken_q <= 1'b0;
            r_pred_ghr_q   <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_sweep_q      <= w_sweep_d;
            r_ghr_q        <= w_ghr_d;
            r_pred_valid_q <= w_pred_valid_d;
            r_pred_taken_q <= w_pred_taken_d;
            r_pred_ghr_q   <= w_pred_ghr_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_d = r_state_q;
        w_sweep_d = r_sweep_q;
        case (r_state_q)
            c_ST_INIT: begin
                if (r_sweep_q == c_SW_LAST) begin
                    w_state_d = c_ST_READY;
                    w_sweep_d = '0;
                end else begin
                    w_sweep_d = r_sweep_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready = (r_state_q == c_ST_READY);
    end

    assign ready_o      = w_ready;
    assign pred_valid_o = r_pred_valid_q;
    assign pred_taken_o = r_pred_taken_q;
    assign pred_ghr_o   = r_pred_ghr_q;
    assign w_unused_pc  = ^{lookup_pc_i, upd_pc_i};

    // ---------------- Lookup path (reads pre-update table contents) ----------------
    logic [GHR_BITS-1:0]   w_lk_glb_idx;
    logic [c_CHO_BITS-1:0] w_lk_cho_idx;
    logic                  w_lk_alt_taken;
    logic                  w_lk_taken;
`ifdef TOURNAMENT_BP_LOCAL_EN
    logic [c_LHT_BITS-1:0] w_lk_lht_idx;
    logic [c_LH_BITS-1:0]  w_lk_hist;
`else
    logic [c_BIM_BITS-1:0] w_lk_bim_idx;
`endif

    always_comb begin
        w_lk_glb_idx = lookup_pc_i[GHR_BITS+c_OFS-1:c_OFS] ^ r_ghr_q;
        w_lk_cho_idx = lookup_pc_i[c_CHO_BITS+c_OFS-1:c_OFS];
`ifdef TOURNAMENT_BP_LOCAL_EN
        w_lk_lht_idx   = lookup_pc_i[c_LHT_BITS+c_OFS-1:c_OFS];
        w_lk_hist      = r_lht_q[w_lk_lht_idx];
        w_lk_alt_taken = r_lcl_q[w_lk_hist][CTR_BITS-1];
`else
        w_lk_bim_idx   = lookup_pc_i[c_BIM_BITS+c_OFS-1:c_OFS];
        w_lk_alt_taken = r_bim_q[w_lk_bim_idx][CTR_BITS-1];
`endif
        w_lk_taken = r_cho_q[w_lk_cho_idx][CTR_BITS-1] ? r_glb_q[w_lk_glb_idx][CTR_BITS-1]
                                                       : w_lk_alt_taken;
    end

    // ---------------- Update path ----------------
    logic [c_BIM_BITS-1:0] w_up_bim_idx;
    logic [GHR_BITS-1:0]   w_up_glb_idx;
    logic [c_CHO_BITS-1:0] w_up_cho_idx;
    logic [CTR_BITS-1:0]   w_up_bim_ctr;
    logic [CTR_BITS-1:0]   w_up_glb_ctr;
    logic [CTR_BITS-1:0]   w_up_cho_ctr;
    logic                  w_up_alt_taken;
    logic                  w_up_disagree;
    logic                  w_up_glb_right;
`ifdef TOURNAMENT_BP_LOCAL_EN
    logic [c_LHT_BITS-1:0] w_up_lht_idx;
    logic [c_LH_BITS-1:0]  w_up_hist;
    logic [CTR_BITS-1:0]   w_up_lcl_ctr;
`endif

    always_comb begin
        w_up_bim_idx = upd_pc_i[c_BIM_BITS+c_OFS-1:c_OFS];
        w_up_glb_idx = upd_pc_i[GHR_BITS+c_OFS-1:c_OFS] ^ upd_ghr_i;
        w_up_cho_idx = upd_pc_i[c_CHO_BITS+c_OFS-1:c_OFS];
        w_up_bim_ctr = r_bim_q[w_up_bim_idx];
        w_up_glb_ctr = r_glb_q[w_up_glb_idx];
        w_up_cho_ctr = r_cho_q[w_up_cho_idx];
`ifdef TOURNAMENT_BP_LOCAL_EN
        w_up_lht_idx   = upd_pc_i[c_LHT_BITS+c_OFS-1:c_OFS];
        w_up_hist      = r_lht_q[w_up_lht_idx];
        w_up_lcl_ctr   = r_lcl_q[w_up_hist];
        w_up_alt_taken = w_up_lcl_ctr[CTR_BITS-1];
`else
        w_up_alt_taken = w_up_bim_ctr[CTR_BITS-1];
`endif
        w_up_disagree  = (w_up_glb_ctr[CTR_BITS-1] != w_up_alt_taken);
        w_up_glb_right = (w_up_glb_ctr[CTR_BITS-1] == upd_taken_i);
    end

    // ---------------- GHR and prediction registers ----------------
    always_comb begin
        w_lk_fire      = lookup_valid_i && w_ready;
        w_up_fire      = upd_valid_i && w_ready && !rst_i;
        w_ghr_d        = r_ghr_q;
        if (!w_ready || flush_i) begin
            w_ghr_d = '0;
        end else if (w_up_fire) begin
            w_ghr_d = {r_ghr_q[GHR_BITS-2:0], upd_taken_i};
        end
        w_pred_valid_d = w_lk_fire;
        w_pred_taken_d = w_lk_fire ? w_lk_taken : r_pred_taken_q;
        w_pred_ghr_d   = w_lk_fire ? r_ghr_q : r_pred_ghr_q;
    end

    // Tables: sweep writes during INIT, trained by resolved branches in READY.
    always_ff @(posedge clk_i) begin
        if (r_state_q == c_ST_INIT) begin
            if (r_sweep_q < c_BIM_LIM) r_bim_q[r_sweep_q[c_BIM_BITS-1:0]] <= c_CTR_WNT;
            if (r_sweep_q < c_GLB_LIM) r_glb_q[r_sweep_q[GHR_BITS-1:0]]   <= c_CTR_WNT;
            if (r_sweep_q < c_CHO_LIM) r_cho_q[r_sweep_q[c_CHO_BITS-1:0]] <= c_CTR_WNT;
`ifdef TOURNAMENT_BP_LOCAL_EN
            if (r_sweep_q < c_LHT_LIM) r_lht_q[r_sweep_q[c_LHT_BITS-1:0]] <= '0;
            if (r_sweep_q < c_LCL_LIM) r_lcl_q[r_sweep_q[c_LH_BITS-1:0]]  <= c_CTR_WNT;
`endif
        end else if (w_up_fire) begin
            r_bim_q[w_up_bim_idx] <= sat_step(w_up_bim_ctr, upd_taken_i);
            r_glb_q[w_up_glb_idx] <= sat_step(w_up_glb_ctr, upd_taken_i);
            if (w_up_disagree) begin
                r_cho_q[w_up_cho_idx] <= sat_step(w_up_cho_ctr, w_up_glb_right);
            end
`ifdef TOURNAMENT_BP_LOCAL_EN
            r_lcl_q[w_up_hist]    <= sat_step(w_up_lcl_ctr, upd_taken_i);
            r_lht_q[w_up_lht_idx] <= {w_up_hist[c_LH_BITS-2:0], upd_taken_i};
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tournament_bp.sv
`default_nettype none
// ============================================================================
// Module   : tb_tournament_bp
// Brief    : Self-checking bench for tournament_bp against a table-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tournament_bp;

    localparam int N    = 1024;
    localparam int GB   = 10;
    localparam int OFS  = 1;
    localparam int HALF = 2;
    localparam int CMAX = 3;
    localparam int WNT  = 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          lookup_valid_i = 1'b0;
    logic [63:0]   lookup_pc_i = '0;
    logic          pred_valid_o;
    logic          pred_taken_o;
    logic [GB-1:0] pred_ghr_o;
    logic          upd_valid_i = 1'b0;
    logic [63:0]   upd_pc_i = '0;
    logic          upd_taken_i = 1'b0;
    logic [GB-1:0] upd_ghr_i = '0;
    logic          ready_o;

    tournament_bp dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_pc_i    (lookup_pc_i),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .pred_ghr_o     (pred_ghr_o),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_ghr_i      (upd_ghr_i),
        .ready_o        (ready_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Model: plain integer tables
    int m_bim [N];
    int m_glb [N];
    int m_cho [N];
    int m_lht [N];
    int m_lcl [N];
    int m_ghr = 0;
    int m_cnt = 0;
    bit m_ready = 0;

    function automatic int tidx(input logic [63:0] pc);
        return int'((pc >> OFS) % N);
    endfunction

    function automatic int sat(input int c, input bit up);
        if (up) return (c < CMAX) ? c + 1 : c;
        return (c > 0) ? c - 1 : c;
    endfunction

    function automatic bit alt_pred(input int i);
`ifdef TOURNAMENT_BP_LOCAL_EN
        return m_lcl[m_lht[i]] >= HALF;
`else
        return m_bim[i] >= HALF;
`endif
    endfunction

    function automatic bit predict(input logic [63:0] pc);
        int i = tidx(pc);
        bit gp = m_glb[i ^ m_ghr] >= HALF;
        return (m_cho[i] >= HALF) ? gp : alt_pred(i);
    endfunction

    task automatic model_init();
        for (int k = 0; k < N; k++) begin
            m_bim[k] = WNT; m_glb[k] = WNT; m_cho[k] = WNT; m_lcl[k] = WNT; m_lht[k] = 0;
        end
        m_ghr = 0;
    endtask

    task automatic model_update(input logic [63:0] pc, input bit t, input int ughr);
        int i  = tidx(pc);
        int gi = i ^ ughr;
        int h  = m_lht[i];
        bit gp = m_glb[gi] >= HALF;
        bit ap = alt_pred(i);
        if (gp != ap) m_cho[i] = sat(m_cho[i], gp == t);
        m_glb[gi] = sat(m_glb[gi], t);
        m_bim[i]  = sat(m_bim[i], t);
`ifdef TOURNAMENT_BP_LOCAL_EN
        m_lcl[h]  = sat(m_lcl[h], t);
        m_lht[i]  = ((h << 1) | int'(t)) % N;
`endif
        m_ghr = ((m_ghr << 1) | int'(t)) % N;
    endtask

    // Expectations computed at drive time, registered at the edge, checked at negedge
    bit nxt_chk = 0, nxt_rst = 0, nxt_valid = 0, nxt_taken = 0, nxt_ready = 0;
    int nxt_ghr = 0;
    bit exp_chk = 0, exp_rst = 0, exp_valid = 0, exp_taken = 0, exp_ready = 0;
    int exp_ghr = 0;

    always @(posedge clk_i) begin
        exp_chk   <= nxt_chk;
        exp_rst   <= nxt_rst;
        exp_valid <= nxt_valid;
        exp_taken <= nxt_taken;
        exp_ready <= nxt_ready;
        exp_ghr   <= nxt_ghr;
    end

    always @(negedge clk_i) begin
        if (exp_chk) begin
            chk("ready", ready_o, exp_ready);
            chk("pred_valid", pred_valid_o, exp_valid);
            if (exp_rst) begin
                chk("rst_pred_taken", pred_taken_o, 0);
                chk("rst_pred_ghr", pred_ghr_o, 0);
            end else if (exp_valid) begin
                chk("pred_taken", pred_taken_o, exp_taken);
                chk("pred_ghr", pred_ghr_o, exp_ghr);
            end
        end
    end

    logic          last_valid, last_taken, last_ready;
    logic [GB-1:0] last_ghr;

    task automatic step(input bit r, input bit fl, input bit lv, input logic [63:0] lpc,
                        input bit uv, input logic [63:0] upc, input bit ut, input int ughr);
        bit pre;
        @(negedge clk_i);
        last_valid = pred_valid_o;
        last_taken = pred_taken_o;
        last_ghr   = pred_ghr_o;
        last_ready = ready_o;
        #1;
        rst_i = r; flush_i = fl; lookup_valid_i = lv; lookup_pc_i = lpc;
        upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_ghr_i = ughr[GB-1:0];
        pre = m_ready;
        if (r) begin
            model_init();
            m_ready = 0; m_cnt = N; nxt_rst = 1; nxt_valid = 0;
        end else begin
            nxt_rst = 0;
            nxt_valid = lv && pre;
            if (nxt_valid) begin
                nxt_taken = predict(lpc);
                nxt_ghr   = m_ghr;
            end
            if (pre && uv) model_update(upc, ut, ughr);
            if (pre && fl) m_ghr = 0;
            if (!pre) begin
                m_cnt--;
                if (m_cnt == 0) m_ready = 1;
            end
        end
        nxt_ready = m_ready;
        nxt_chk = 1;
    endtask

    task automatic idle();
        step(0, 0, 0, 64'd0, 0, 64'd0, 0, 0);
    endtask

    task automatic lookup(input logic [63:0] pc);
        step(0, 0, 1, pc, 0, 64'd0, 0, 0);
        idle();
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 2000) begin
            idle();
            if (last_ready === 1'b1) seen = 1;
            else n++;
        end
        chk(nm, seen ? n : 9999, N);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pc;
        step(1, 0, 0, 64'd0, 0, 64'd0, 0, 0);
        step(1, 0, 0, 64'd0, 0, 64'd0, 0, 0);
        wait_ready("ready_after_reset");

        lookup(64'h8000_0000);
        chk("first_valid", last_valid, 1);
        chk("first_taken", last_taken, 0);
        chk("first_ghr", last_ghr, 0);

`ifndef TOURNAMENT_BP_LOCAL_EN
        // Always-taken branch trained through its own prediction snapshots
        for (int k = 0; k < 4; k++) begin
            lookup(64'h8000_0100);
            step(0, 0, 0, 64'd0, 1, 64'h8000_0100, 1, int'(last_ghr));
        end
        lookup(64'h8000_0100);
        chk("always_taken_pred", last_taken, 1);
        chk("always_taken_ghr", last_ghr, 15);

        // Saturation at zero, then climb back
        for (int k = 0; k < 10; k++) step(0, 0, 0, 64'd0, 1, 64'h8000_0200, 0, m_ghr);
        lookup(64'h8000_0200);
        chk("sat_low_pred", last_taken, 0);
        step(0, 0, 0, 64'd0, 1, 64'h8000_0200, 1, m_ghr);
        lookup(64'h8000_0200);
        chk("sat_one_taken_pred", last_taken, 0);
        step(0, 0, 0, 64'd0, 1, 64'h8000_0200, 1, m_ghr);
        lookup(64'h8000_0200);
        chk("sat_two_taken_pred", last_taken, 1);

        // Same-cycle lookup and update returns the old counter
        step(0, 0, 1, 64'h8000_0300, 1, 64'h8000_0300, 1, m_ghr);
        idle();
        chk("rbw_old_pred", last_taken, 0);
        lookup(64'h8000_0300);
        chk("rbw_new_pred", last_taken, 1);
`else
        // Alternating branch: local history learns the pattern
        for (int k = 0; k < 20; k++) step(0, 0, 0, 64'd0, 1, 64'h8000_0400, k[0], m_ghr);
        for (int k = 20; k < 24; k++) begin
            lookup(64'h8000_0400);
            chk("alternating_pred", last_taken, k[0]);
            step(0, 0, 0, 64'd0, 1, 64'h8000_0400, k[0], m_ghr);
        end
`endif

        // Flush beats a same-cycle update on the GHR
        step(0, 1, 0, 64'd0, 1, 64'h8000_0500, 1, m_ghr);
        lookup(64'h8000_0500);
        chk("flush_with_update_ghr", last_ghr, 0);

        // Reset mid-sweep restarts the full sweep
        step(1, 0, 0, 64'd0, 0, 64'd0, 0, 0);
        repeat (500) idle();
        step(1, 0, 0, 64'd0, 0, 64'd0, 0, 0);
        wait_ready("ready_after_midsweep_reset");

        for (int k = 0; k < 4000; k++) begin
            bit r, fl, lv, uv, ut;
            logic [63:0] upc;
            int ug;
            r  = ($urandom_range(0, 2999) == 0);
            fl = ($urandom_range(0, 15) == 0);
            lv = ($urandom_range(0, 3) != 0);
            uv = ($urandom_range(0, 1) == 1);
            ut = ($urandom_range(0, 2) != 0);
            pc  = 64'h8000_0000 + 64'($urandom_range(0, 15) << 1);
            upc = 64'h8000_0000 + 64'($urandom_range(0, 15) << 1);
            if ($urandom_range(0, 7) == 0) pc = {$urandom, $urandom};
            ug = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : m_ghr;
            step(r, fl, lv, pc, uv, upc, ut, ug);
        end
        idle();
        idle();
        nxt_chk = 0;
        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
